timer_mc: RTL and testbench
===========================

Name: timer_mc

Overview:
- Parametrised multi-channel down-counting timer; successor to the single-channel memory-mapped timer on the CPU peripheral bus.
- N_CH independent channels, each with CTRL/PRESET/COUNT/STATUS words, one-shot or auto-reload mode, and a sticky, maskable, write-1-to-clear interrupt flag.
- A single OR-combined IntReq feeds the CP0 interrupt input.

Parameters:
- N_CH, 2: number of channels, 1..8.
- CH_BITS, 1: channel-select address bits; requires 2**CH_BITS >= N_CH.
- CNT_W, 32: PRESET/COUNT width, 8..32; reads zero-extended to 32 bits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- addr  in  [CH_BITS+3:2]  word address; addr[CH_BITS+3:4] = channel, addr[3:2] = register.
- we  in  1  write strobe, sampled at the clk edge.
- Din  in  32  write data.
- Dout  out  32  combinational read data.
- IntReq  out  1  registered interrupt request; OR over channels of (pend & IM).

Behaviour:
- Register map per channel:
  - 00 CTRL RW: [0]EN, [2:1]MODE (00 one-shot, 01 auto-reload, 1x reserved = one-shot), [3]IM, rest 0.
  - 01 PRESET RW, CNT_W bits.
  - 10 COUNT RO.
  - 11 STATUS: [0]PEND, [3:1]state code; write 1 to bit0 clears PEND.
- Channel index >= N_CH: reads 0, writes ignored. Writes to COUNT are ignored.
- Reset (reset=0, asynchronous): all CTRL/PRESET/COUNT/PEND = 0, every FSM in IDLE, IntReq=0.
- Per-channel FSM (state code): IDLE(0), LOAD(1), COUNT(2), INT(3).
  - IDLE -> LOAD when EN=1.
  - LOAD: COUNT <= PRESET; -> COUNT.
  - COUNT: if COUNT==0 -> INT, else COUNT <= COUNT-1 and stay.
  - INT: PEND <= 1 on entry to INT. One-shot: EN <= 0, -> IDLE. Auto-reload: -> LOAD.
  - Any state with EN=0 (after the CTRL write) -> IDLE next edge. COUNT holds its value; PEND is unaffected.
- Timing, with the CTRL write of EN=1 at edge E0 and PRESET=P:
  - LOAD at E1, COUNT at E2, INT entered (PEND set) at E(P+3).
  - Auto-reload period: P+3 cycles.
  - PRESET=0 is legal: INT at E3, period 3.
  - Wrap-around is impossible because COUNT never decrements below 0.
- A PRESET write while counting affects only the next LOAD; it does not restart the channel.
- Writing PRESET does NOT set EN, unlike the previous timer. Software must write CTRL.
- Simultaneous events:
  - Hardware PEND set and W1C on the same edge: set wins.
  - CTRL write clearing EN on the same edge the FSM is in INT: the write wins; EN=0, FSM goes to IDLE.
- IntReq is registered: it reflects PEND & IM one cycle after either changes.
- Setting IM while PEND=1 raises IntReq; clearing IM drops it.
- Dout = selected register, upper bits zero-filled. Reads have no side effects.

Optional Feature:
- Macro TIMER_MC_PRESCALE_EN.
- Defined:
  - CTRL[15:8] = 8-bit prescale S, RW.
  - A per-channel prescale counter reloads to S in LOAD. In COUNT, the decrement and the zero test occur only on ticks, when the prescale counter is 0; otherwise the prescale counter decrements.
  - Period = (P+1)*(S+1)+2.
  - STATUS[15:8] reads the live prescale counter.
- Undefined:
  - CTRL[15:8] and STATUS[15:8] read 0; writes to them are ignored.
  - A tick occurs every cycle, so timing equals S=0.

Test Plan:
- Reset: drive reset=0 mid-count (ch0 COUNT=5) -> all registers read 0 immediately, IntReq=0; after release, IDLE with no spurious interrupt.
- One-shot: ch0 PRESET=4, CTRL=0x9 (EN, IM, one-shot) at E0 -> STATUS.PEND=1 at E7, IntReq=1 at E8, CTRL reads 0x8; W1C STATUS=1 -> IntReq=0 one cycle later.
- Auto-reload on ch1 with PRESET=2, CTRL=0xB -> PEND rises every 5 cycles. Ch0 runs one-shot P=10 concurrently; both interrupts are observed with correct addressing, and ch0 registers are unaffected by ch1 writes.
- Abort and edge cases:
  - CTRL=0 while ch0 COUNT=3 -> IDLE next edge, COUNT holds 3, no PEND.
  - PRESET=0 -> INT at E3.
  - Access to channel 3 with N_CH=2 -> reads 0.
- Simultaneous events:
  - W1C on the edge PEND is set -> PEND stays 1.
  - PRESET rewritten to 7 mid-count -> current period unchanged, next period 10 cycles.
- TIMER_MC_PRESCALE_EN: CTRL S=3, P=1, auto-reload -> period 10 cycles; STATUS[15:8] cycles 3,2,1,0.

Source files
------------

// File: rtl/timer_mc.sv
// timer_mc: N_CH-channel down-counting timer, one-shot/auto-reload, W1C IRQ.
// Define TIMER_MC_PRESCALE_EN for an 8-bit per-channel prescaler in CTRL[15:8].
module timer_mc #(
  parameter int N_CH    = 2,
  parameter int CH_BITS = 1,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [CH_BITS+3:2] addr,
  input  logic               we,
  input  logic [31:0]        Din,
  output logic [31:0]        Dout,
  output logic               IntReq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } st_t;

  localparam logic [1:0] R_CTRL = 2'd0;
  localparam logic [1:0] R_PRE  = 2'd1;
  localparam logic [1:0] R_CNT  = 2'd2;
  localparam logic [1:0] R_ST   = 2'd3;

  logic [CH_BITS-1:0] ch;
  logic [1:0]         rs;
  logic [31:0]        ch_rd [N_CH];
  logic [N_CH-1:0]    irq;
  logic               unused_din;

  assign ch = addr[CH_BITS+3:4];
  assign rs = addr[3:2];
  assign unused_din = ^Din;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic             sel;
    logic             wr_ctrl;
    logic             wr_pre;
    logic             wr_st;
    logic             en_q;
    logic             im_q;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] pre_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pend_q;
    st_t              st_q;
    st_t              st_d;
    logic             en_eff;
    logic             auto_rl;
    logic             tick;
    logic             do_load;
    logic             do_dec;
    logic             set_pend;
    logic             clr_en;
    logic [31:0]      rd;

    assign sel     = we && (ch == CH_BITS'(g));
    assign wr_ctrl = sel && (rs == R_CTRL);
    assign wr_pre  = sel && (rs == R_PRE);
    assign wr_st   = sel && (rs == R_ST);
    // a CTRL write on this edge overrides the stored EN for abort decisions
    assign en_eff  = wr_ctrl ? Din[0] : en_q;
    assign auto_rl = (mode_q == 2'b01);

`ifdef TIMER_MC_PRESCALE_EN
    logic [7:0] s_q;
    logic [7:0] psc_q;

    assign tick = (psc_q == 8'd0);

    // prescale value and live prescale counter
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        s_q   <= 8'd0;
        psc_q <= 8'd0;
      end else begin
        if (wr_ctrl)
          s_q <= Din[15:8];
        if (do_load)
          psc_q <= s_q;
        else if (en_eff && st_q == S_CNT)
          psc_q <= tick ? s_q : psc_q - 8'd1;
      end
    end
`else
    assign tick = 1'b1;
`endif

    // state register
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)
        st_q <= S_IDLE;
      else
        st_q <= st_d;
    end

    // next-state logic; a cleared EN forces IDLE from any state
    always_comb begin
      st_d = st_q;
      unique case (st_q)
        S_IDLE: if (en_q) st_d = S_LOAD;
        S_LOAD: st_d = S_CNT;
        S_CNT:  if (tick && cnt_q == '0) st_d = S_INT;
        S_INT:  st_d = auto_rl ? S_LOAD : S_IDLE;
        default: st_d = S_IDLE;
      endcase
      if (!en_eff)
        st_d = S_IDLE;
    end

    // per-state actions, suppressed on the abort edge
    always_comb begin
      do_load  = 1'b0;
      do_dec   = 1'b0;
      set_pend = 1'b0;
      clr_en   = 1'b0;
      if (en_eff) begin
        unique case (st_q)
          S_LOAD: do_load = 1'b1;
          S_CNT: begin
            do_dec   = tick && (cnt_q != '0);
            set_pend = tick && (cnt_q == '0);
          end
          S_INT: clr_en = !auto_rl;
          default: ;
        endcase
      end
    end

    // CTRL/PRESET/COUNT/PEND; software CTRL write beats the one-shot EN clear
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        en_q   <= 1'b0;
        im_q   <= 1'b0;
        mode_q <= 2'b00;
        pre_q  <= '0;
        cnt_q  <= '0;
        pend_q <= 1'b0;
      end else begin
        if (wr_ctrl) begin
          en_q   <= Din[0];
          mode_q <= Din[2:1];
          im_q   <= Din[3];
        end else if (clr_en) begin
          en_q <= 1'b0;
        end
        if (wr_pre)
          pre_q <= Din[CNT_W-1:0];
        if (do_load)
          cnt_q <= pre_q;
        else if (do_dec)
          cnt_q <= cnt_q - CNT_W'(1);
        if (set_pend)
          pend_q <= 1'b1;
        else if (wr_st && Din[0])
          pend_q <= 1'b0;
      end
    end

    // read word for this channel
    always_comb begin
      rd = 32'd0;
      unique case (rs)
        R_CTRL: begin
          rd[3:0] = {im_q, mode_q, en_q};
`ifdef TIMER_MC_PRESCALE_EN
          rd[15:8] = s_q;
`endif
        end
        R_PRE: rd = 32'(pre_q);
        R_CNT: rd = 32'(cnt_q);
        R_ST: begin
          rd[3:0] = {1'b0, st_q, pend_q};
`ifdef TIMER_MC_PRESCALE_EN
          rd[15:8] = psc_q;
`endif
        end
        default: rd = 32'd0;
      endcase
    end

    assign ch_rd[g] = rd;
    assign irq[g]   = pend_q & im_q;
  end

  // channel read mux; unpopulated channels read zero
  always_comb begin
    Dout = 32'd0;
    for (int i = 0; i < N_CH; i++)
      if (ch == CH_BITS'(i))
        Dout = ch_rd[i];
  end

  // registered interrupt request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      IntReq <= 1'b0;
    else
      IntReq <= |irq;
  end

endmodule

// File: tb/tb_timer_mc.sv
// tb_timer_mc: directed test of timer_mc with hand-computed expectations.
// N_CH=2, CH_BITS=2 so that channels 2 and 3 are addressable but absent.
module tb_timer_mc;

  localparam int N_CH    = 2;
  localparam int CH_BITS = 2;
  localparam int CNT_W   = 16;

  localparam logic [1:0] R_CTRL = 2'd0;
  localparam logic [1:0] R_PRE  = 2'd1;
  localparam logic [1:0] R_CNT  = 2'd2;
  localparam logic [1:0] R_ST   = 2'd3;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [CH_BITS+3:2] addr = '0;
  logic               we = 1'b0;
  logic [31:0]        Din = '0;
  logic [31:0]        Dout;
  logic               IntReq;

  int checks = 0;
  int failures = 0;

  timer_mc #(
    .N_CH   (N_CH),
    .CH_BITS(CH_BITS),
    .CNT_W  (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .Din   (Din),
    .Dout  (Dout),
    .IntReq(IntReq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input int c, input logic [1:0] r, input logic [31:0] d);
    @(negedge clk);
    addr = {c[1:0], r};
    we   = 1'b1;
    Din  = d;
    @(posedge clk);
    #1 we = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_rd(input string tag, input int c, input logic [1:0] r,
                        input logic [31:0] exp);
    addr = {c[1:0], r};
    #1 chk(tag, Dout, exp);
  endtask

  initial begin
    // reset state
    step(2);
    chk_rd("rst_ctrl", 0, R_CTRL, 32'h0);
    chk_rd("rst_cnt", 0, R_CNT, 32'h0);
    chk("rst_irq", 32'(IntReq), 32'h0);
    @(negedge clk) reset = 1'b1;
    step(1);

    // one-shot ch0, P=4: PEND at E7, IntReq at E8
    wr(0, R_PRE, 4);
    wr(0, R_CTRL, 32'h9);
    step(6);
    chk_rd("os_st_e6", 0, R_ST, 32'h4);
    chk_rd("os_cnt_e6", 0, R_CNT, 32'h0);
    step(1);
    chk_rd("os_st_e7", 0, R_ST, 32'h7);
    chk("os_irq_e7", 32'(IntReq), 32'h0);
    step(1);
    chk("os_irq_e8", 32'(IntReq), 32'h1);
    chk_rd("os_st_e8", 0, R_ST, 32'h1);
    chk_rd("os_ctrl_e8", 0, R_CTRL, 32'h8);
    wr(0, R_ST, 1);
    chk("w1c_irq_hold", 32'(IntReq), 32'h1);
    chk_rd("w1c_st", 0, R_ST, 32'h0);
    step(1);
    chk("w1c_irq_drop", 32'(IntReq), 32'h0);

    // ch1 auto-reload P=2 (period 5) with ch0 one-shot P=10
    wr(1, R_PRE, 2);
    wr(0, R_PRE, 10);
    wr(1, R_CTRL, 32'hB);
    wr(0, R_CTRL, 32'h9);
    step(3);
    chk_rd("ar_st_e4", 1, R_ST, 32'h4);
    step(1);
    chk_rd("ar_st_e5", 1, R_ST, 32'h7);
    chk("ar_irq_e5", 32'(IntReq), 32'h0);
    wr(1, R_ST, 1);
    chk_rd("ar_st_e6", 1, R_ST, 32'h2);
    step(3);
    chk_rd("ar_st_e9", 1, R_ST, 32'h4);
    step(1);
    chk_rd("ar_st_e10", 1, R_ST, 32'h7);
    chk_rd("c0_cnt_e10", 0, R_CNT, 32'd3);
    step(1);
    chk("ar_irq_e11", 32'(IntReq), 32'h1);
    chk_rd("c0_ctrl_e11", 0, R_CTRL, 32'h9);
    chk_rd("c0_pre_e11", 0, R_PRE, 32'd10);
    step(3);
    chk_rd("c0_st_e14", 0, R_ST, 32'h7);
    step(1);
    chk_rd("c0_st_e15", 0, R_ST, 32'h1);
    chk_rd("c0_ctrl_e15", 0, R_CTRL, 32'h8);
    chk_rd("ar_st_e15", 1, R_ST, 32'h7);
    wr(1, R_CTRL, 0);
    chk_rd("int_abort_st", 1, R_ST, 32'h1);
    chk_rd("int_abort_ctrl", 1, R_CTRL, 32'h0);
    wr(1, R_ST, 1);
    wr(0, R_ST, 1);
    chk("clr_irq_hold", 32'(IntReq), 32'h1);
    step(1);
    chk("clr_irq_drop", 32'(IntReq), 32'h0);
    chk_rd("clr_st0", 0, R_ST, 32'h0);
    chk_rd("clr_st1", 1, R_ST, 32'h0);

    // abort at COUNT=3; COUNT holds, writes to COUNT ignored
    wr(0, R_PRE, 6);
    wr(0, R_CTRL, 32'h1);
    step(5);
    chk_rd("ab_cnt_pre", 0, R_CNT, 32'd3);
    wr(0, R_CTRL, 0);
    chk_rd("ab_st", 0, R_ST, 32'h0);
    chk_rd("ab_cnt", 0, R_CNT, 32'd3);
    wr(0, R_CNT, 32'h55);
    step(3);
    chk_rd("ab_st_late", 0, R_ST, 32'h0);
    chk_rd("ab_cnt_late", 0, R_CNT, 32'd3);
    chk("ab_irq", 32'(IntReq), 32'h0);

    // PRESET=0: INT at E3
    wr(0, R_PRE, 0);
    wr(0, R_CTRL, 32'h9);
    step(2);
    chk_rd("p0_st_e2", 0, R_ST, 32'h4);
    step(1);
    chk_rd("p0_st_e3", 0, R_ST, 32'h7);
    step(1);
    chk("p0_irq_e4", 32'(IntReq), 32'h1);
    chk_rd("p0_st_e4", 0, R_ST, 32'h1);
    wr(0, R_ST, 1);

    // W1C on the edge PEND is set: set wins
    wr(1, R_PRE, 2);
    wr(1, R_CTRL, 32'hB);
    step(4);
    wr(1, R_ST, 1);
    chk_rd("race_st_e5", 1, R_ST, 32'h7);
    wr(1, R_ST, 1);
    chk_rd("race_st_e6", 1, R_ST, 32'h2);
    wr(1, R_CTRL, 0);

    // PRESET rewritten mid-count: next period becomes 10
    wr(1, R_PRE, 2);
    wr(1, R_CTRL, 32'h3);
    step(2);
    wr(1, R_PRE, 7);
    step(1);
    chk_rd("pw_st_e4", 1, R_ST, 32'h4);
    step(1);
    chk_rd("pw_st_e5", 1, R_ST, 32'h7);
    wr(1, R_ST, 1);
    chk_rd("pw_st_e6", 1, R_ST, 32'h2);
    step(8);
    chk_rd("pw_st_e14", 1, R_ST, 32'h4);
    chk_rd("pw_cnt_e14", 1, R_CNT, 32'h0);
    step(1);
    chk_rd("pw_st_e15", 1, R_ST, 32'h7);
    chk("pw_irq_masked", 32'(IntReq), 32'h0);
    wr(1, R_CTRL, 32'hB);
    step(1);
    chk("im_set_irq", 32'(IntReq), 32'h1);
    wr(1, R_CTRL, 0);
    step(1);
    chk("im_clr_irq", 32'(IntReq), 32'h0);
    wr(1, R_ST, 1);

    // absent channels read zero and do not alias
    wr(3, R_CTRL, 32'h9);
    wr(3, R_PRE, 5);
    wr(2, R_PRE, 6);
    chk_rd("ch3_ctrl", 3, R_CTRL, 32'h0);
    chk_rd("ch3_pre", 3, R_PRE, 32'h0);
    chk_rd("ch2_pre", 2, R_PRE, 32'h0);
    step(1);
    chk_rd("alias_pre1", 1, R_PRE, 32'd7);
    chk_rd("alias_pre0", 0, R_PRE, 32'd0);
    chk_rd("ch3_st", 3, R_ST, 32'h0);
    step(1);
    chk_rd("alias_st1", 1, R_ST, 32'h0);
    chk("alias_irq", 32'(IntReq), 32'h0);

`ifdef TIMER_MC_PRESCALE_EN
    // S=3, P=1, auto-reload: period 10, prescale counts 3,2,1,0
    wr(0, R_PRE, 1);
    wr(0, R_CTRL, 32'h303);
    step(2);
    chk_rd("ps_e2", 0, R_ST, 32'h304);
    step(1);
    chk_rd("ps_e3", 0, R_ST, 32'h204);
    step(1);
    chk_rd("ps_e4", 0, R_ST, 32'h104);
    step(1);
    chk_rd("ps_e5", 0, R_ST, 32'h004);
    step(4);
    chk_rd("ps_e9", 0, R_ST, 32'h004);
    step(1);
    chk_rd("ps_e10", 0, R_ST, 32'h307);
    wr(0, R_ST, 1);
    chk_rd("ps_e11", 0, R_ST, 32'h302);
    step(8);
    chk_rd("ps_e19", 0, R_ST, 32'h004);
    step(1);
    chk_rd("ps_e20", 0, R_ST, 32'h307);
    wr(0, R_CTRL, 0);
    wr(0, R_ST, 1);
`else
    // prescale field absent: CTRL[15:8] ignored
    wr(0, R_CTRL, 32'hFF00);
    chk_rd("nops_ctrl", 0, R_CTRL, 32'h0);
    chk_rd("nops_st", 0, R_ST, 32'h0);
`endif

    // asynchronous reset mid-count with an interrupt pending
    wr(1, R_PRE, 0);
    wr(1, R_CTRL, 32'h9);
    wr(0, R_PRE, 20);
    wr(0, R_CTRL, 32'h1);
    step(17);
    chk("pre_rst_irq", 32'(IntReq), 32'h1);
    chk_rd("pre_rst_cnt", 0, R_CNT, 32'd5);
    reset = 1'b0;
    #1 chk("arst_irq", 32'(IntReq), 32'h0);
    chk_rd("arst_cnt", 0, R_CNT, 32'h0);
    @(negedge clk);
    chk_rd("arst_pre", 0, R_PRE, 32'h0);
    chk_rd("arst_st1", 1, R_ST, 32'h0);
    @(negedge clk) reset = 1'b1;
    step(10);
    chk("post_rst_irq", 32'(IntReq), 32'h0);
    chk_rd("post_rst_st0", 0, R_ST, 32'h0);
    chk_rd("post_rst_ctrl1", 1, R_CTRL, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
